// File: rtl/spi_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module  : spi_ctrl_pkg
// Purpose : Shared command codes, controller states and defaults for the
//           SPI command controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package spi_ctrl_pkg;

   localparam int IMG_BYTES_DEFAULT      = 128;
   localparam int TIMEOUT_CYCLES_DEFAULT = 100000;

   typedef enum logic [7:0] {
      CMD_NOP   = 8'h00,
      CMD_LOAD  = 8'h01,
      CMD_CLEAR = 8'h02,
      CMD_INFER = 8'h03
   } cmd_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CLEAR = 3'd2,
      S_INFER = 3'd3,
      S_WAIT  = 3'd4
   } ctrl_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_cmd_controller.sv
//------------------------------------------------------------------------------
// Module  : spi_cmd_controller
// Purpose : Decodes single-byte SPI commands, streams image payload into the
//           image buffer, clears the buffer and sequences BNN inference.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_cmd_controller
   import spi_ctrl_pkg::*;
#(
   parameter int IMG_BYTES      = IMG_BYTES_DEFAULT,
   parameter int ADDR_W         = $clog2(IMG_BYTES),
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        i_spi_rx_data,
   input  logic              i_byte_valid,
   output logic              o_byte_taken,
   output logic              o_rx_enable,
   output logic              o_img_wr_en,
   output logic [ADDR_W-1:0] o_img_wr_addr,
   output logic [7:0]        o_img_wr_data,
   output logic              o_infer_start,
   input  logic              i_infer_done,
   output logic              o_img_loaded,
   output logic              o_busy,
   output logic              o_cmd_error
);

   localparam int                TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(IMG_BYTES - 1);
   localparam logic [TO_W-1:0]   c_TO_TERM = TO_W'(TIMEOUT_CYCLES - 1);

   ctrl_state_e       r_state, w_state_nxt;
   logic              r_guard;
   logic [ADDR_W-1:0] r_byte_cnt, w_byte_cnt_nxt;
   logic [TO_W-1:0]   r_to_cnt, w_to_cnt_nxt;
   logic              r_byte_taken;
   logic              r_wr_en, w_wr_en_nxt;
   logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
   logic [7:0]        r_wr_data, w_wr_data_nxt;
   logic              r_infer_start, w_infer_start_nxt;
   logic              r_img_loaded, w_img_loaded_nxt;
   logic              r_cmd_error, w_cmd_error_nxt;

   logic              w_consume;
   logic              w_accept;
   logic              w_timeout;
   cmd_e              w_cmd;

   assign w_consume = (r_state == S_IDLE) || (r_state == S_LOAD);
   assign w_accept  = i_byte_valid && !r_guard && w_consume;
   // An accept on the terminal count wins over the timeout.
   assign w_timeout = (r_state == S_LOAD) && !w_accept && (r_to_cnt == c_TO_TERM);
   assign w_cmd     = cmd_e'(i_spi_rx_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_byte_cnt_nxt    = r_byte_cnt;
      w_to_cnt_nxt      = '0;
      w_wr_en_nxt       = 1'b0;
      w_wr_addr_nxt     = r_wr_addr;
      w_wr_data_nxt     = r_wr_data;
      w_infer_start_nxt = 1'b0;
      w_img_loaded_nxt  = r_img_loaded;
      w_cmd_error_nxt   = r_cmd_error;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (w_cmd)
                  CMD_NOP: w_cmd_error_nxt = 1'b0;
                  CMD_LOAD: begin
                     w_cmd_error_nxt  = 1'b0;
                     w_img_loaded_nxt = 1'b0;
                     w_byte_cnt_nxt   = '0;
                     w_state_nxt      = S_LOAD;
                  end
                  CMD_CLEAR: begin
                     // First clear write issues with the command so every
                     // S_CLEAR cycle carries exactly one write.
                     w_cmd_error_nxt  = 1'b0;
                     w_img_loaded_nxt = 1'b0;
                     w_byte_cnt_nxt   = '0;
                     w_wr_en_nxt      = 1'b1;
                     w_wr_addr_nxt    = '0;
                     w_wr_data_nxt    = 8'h00;
                     w_state_nxt      = S_CLEAR;
                  end
                  CMD_INFER: begin
                     if (r_img_loaded) begin
                        w_cmd_error_nxt   = 1'b0;
                        w_infer_start_nxt = 1'b1;
                        w_state_nxt       = S_INFER;
                     end else begin
                        w_cmd_error_nxt = 1'b1;
                     end
                  end
                  default: w_cmd_error_nxt = 1'b1;
               endcase
            end
         end
         S_LOAD: begin
            if (w_accept) begin
               w_wr_en_nxt   = 1'b1;
               w_wr_addr_nxt = r_byte_cnt;
               w_wr_data_nxt = i_spi_rx_data;
               if (r_byte_cnt == c_LAST) begin
                  w_img_loaded_nxt = 1'b1;
                  w_state_nxt      = S_IDLE;
               end else begin
                  w_byte_cnt_nxt = r_byte_cnt + 1'b1;
               end
            end else if (w_timeout) begin
               w_cmd_error_nxt = 1'b1;
               w_state_nxt     = S_IDLE;
            end else begin
               w_to_cnt_nxt = r_to_cnt + 1'b1;
            end
         end
         S_CLEAR: begin
            if (r_wr_addr == c_LAST) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_wr_en_nxt   = 1'b1;
               w_wr_addr_nxt = r_wr_addr + 1'b1;
               w_wr_data_nxt = 8'h00;
            end
         end
         S_INFER: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (i_infer_done) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_guard       <= 1'b0;
         r_byte_cnt    <= '0;
         r_to_cnt      <= '0;
         r_byte_taken  <= 1'b0;
         r_wr_en       <= 1'b0;
         r_wr_addr     <= '0;
         r_wr_data     <= 8'h00;
         r_infer_start <= 1'b0;
         r_img_loaded  <= 1'b0;
         r_cmd_error   <= 1'b0;
      end else begin
         // Guard blocks re-taking the same byte while the receiver still holds it.
         r_guard       <= w_accept || (r_guard && i_byte_valid);
         r_byte_cnt    <= w_byte_cnt_nxt;
         r_to_cnt      <= w_to_cnt_nxt;
         r_byte_taken  <= w_accept;
         r_wr_en       <= w_wr_en_nxt;
         r_wr_addr     <= w_wr_addr_nxt;
         r_wr_data     <= w_wr_data_nxt;
         r_infer_start <= w_infer_start_nxt;
         r_img_loaded  <= w_img_loaded_nxt;
         r_cmd_error   <= w_cmd_error_nxt;
      end
   end

   assign o_byte_taken  = r_byte_taken;
   assign o_rx_enable   = rst_n && w_consume;
   assign o_img_wr_en   = r_wr_en;
   assign o_img_wr_addr = r_wr_addr;
   assign o_img_wr_data = r_wr_data;
   assign o_infer_start = r_infer_start;
   assign o_img_loaded  = r_img_loaded;
   assign o_busy        = (r_state != S_IDLE);
   assign o_cmd_error   = r_cmd_error;

endmodule

`default_nettype wire

// File: tb/tb_spi_cmd_controller.sv
//------------------------------------------------------------------------------
// Module  : tb_spi_cmd_controller
// Purpose : Directed scoreboard bench for spi_cmd_controller.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_cmd_controller;

   localparam int IMG_BYTES = 128;
   localparam int ADDR_W    = 7;
   localparam int TB_TO     = 300;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [7:0]        i_spi_rx_data = 8'h00;
   logic              i_byte_valid = 1'b0;
   logic              i_infer_done = 1'b0;
   logic              o_byte_taken, o_rx_enable, o_img_wr_en, o_infer_start;
   logic [ADDR_W-1:0] o_img_wr_addr;
   logic [7:0]        o_img_wr_data;
   logic              o_img_loaded, o_busy, o_cmd_error;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_taken  = 0;
   logic [15:0] q_wr[$];
   int          q_inf[$];
   logic [15:0] exp_wr;

   spi_cmd_controller #(
      .IMG_BYTES(IMG_BYTES), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TB_TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_spi_rx_data(i_spi_rx_data),
      .i_byte_valid(i_byte_valid), .o_byte_taken(o_byte_taken),
      .o_rx_enable(o_rx_enable), .o_img_wr_en(o_img_wr_en),
      .o_img_wr_addr(o_img_wr_addr), .o_img_wr_data(o_img_wr_data),
      .o_infer_start(o_infer_start), .i_infer_done(i_infer_done),
      .o_img_loaded(o_img_loaded), .o_busy(o_busy), .o_cmd_error(o_cmd_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops expected writes / inference starts as the DUT presents them.
   always @(negedge clk) begin
      if (o_byte_taken) n_taken++;
      if (o_img_wr_en) begin
         if (q_wr.size() == 0) begin
            chk("wr_unexpected", {o_img_wr_addr, o_img_wr_data}, 32'hFFFF_FFFF);
         end else begin
            exp_wr = q_wr.pop_front();
            chk("wr_addr", 32'(o_img_wr_addr), 32'(exp_wr[15:8]));
            chk("wr_data", 32'(o_img_wr_data), 32'(exp_wr[7:0]));
         end
      end
      if (o_infer_start) begin
         if (q_inf.size() == 0) chk("infer_start_unexpected", 1, 0);
         else void'(q_inf.pop_front());
      end
   end

   task automatic send(input logic [7:0] b, input int hold);
      bit got = 0;
      @(posedge clk); #1;
      i_spi_rx_data = b;
      i_byte_valid  = 1'b1;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (o_byte_taken) got = 1;
      end
      if (!got) chk("byte_taken_timeout", 0, 1);
      repeat (hold) @(posedge clk);
      @(posedge clk); #1;
      i_byte_valid = 1'b0;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, cnt, nbusy, bad_rx, gaps, tk_during;
      bit got;

      // 1: reset values
      repeat (2) @(negedge clk);
      chk("rst_rx_enable", o_rx_enable, 0);
      chk("rst_busy_taken_wr_start", {o_busy, o_byte_taken, o_img_wr_en, o_infer_start}, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("idle_rx_enable", o_rx_enable, 1);
      chk("idle_flags", {o_busy, o_img_loaded, o_cmd_error, o_img_wr_en}, 0);

      // 2: full image load
      t0 = n_taken;
      send(8'h01, 1);
      for (int i = 0; i < IMG_BYTES; i++) begin
         q_wr.push_back({8'(i), 8'(i)});
         send(8'(i), i % 3);
      end
      repeat (3) @(negedge clk);
      chk("load_taken_count", n_taken - t0, IMG_BYTES + 1);
      chk("load_img_loaded", o_img_loaded, 1);
      chk("load_busy", o_busy, 0);
      chk("load_writes_left", q_wr.size(), 0);

      // 3: inference
      q_inf.push_back(1);
      send(8'h03, 0);
      bad_rx = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (o_rx_enable || !o_busy) bad_rx++;
      end
      chk("infer_rx_disabled", bad_rx, 0);
      chk("infer_start_seen", q_inf.size(), 0);
      @(posedge clk); #1 i_infer_done = 1'b1;
      @(posedge clk); #1 i_infer_done = 1'b0;
      @(negedge clk);
      chk("infer_done_idle", {o_busy, o_rx_enable, o_img_loaded}, 3'b011);
      do_reset();
      send(8'h03, 0);
      repeat (3) @(negedge clk);
      chk("infer_unloaded_error", {o_cmd_error, o_busy}, 2'b10);

      // 4: payload timeout
      send(8'h01, 0);
      for (int i = 0; i < 5; i++) begin
         q_wr.push_back({8'(i), 8'hC0 + 8'(i)});
         send(8'hC0 + 8'(i), 0);
      end
      cnt = 0;
      while (o_busy && cnt < 2 * TB_TO) begin
         @(negedge clk);
         cnt++;
      end
      chk("timeout_latency_ok", (cnt >= TB_TO - 8) && (cnt <= TB_TO + 8), 1);
      chk("timeout_flags", {o_busy, o_cmd_error, o_img_loaded}, 3'b010);
      send(8'h00, 0);
      @(negedge clk);
      chk("nop_clears_error", o_cmd_error, 0);

      // 5: illegal command, valid held past taken
      t0 = n_taken;
      send(8'h7E, 2);
      repeat (3) @(negedge clk);
      chk("illegal_single_take", n_taken - t0, 1);
      chk("illegal_flags", {o_cmd_error, o_busy, o_rx_enable}, 3'b101);

      // 6: load then clear
      send(8'h01, 0);
      for (int i = 0; i < IMG_BYTES; i++) begin
         q_wr.push_back({8'(i), 8'(i) ^ 8'hA5});
         send(8'(i) ^ 8'hA5, 1);
      end
      repeat (2) @(negedge clk);
      chk("reload_img_loaded", o_img_loaded, 1);
      for (int i = 0; i < IMG_BYTES; i++) q_wr.push_back({8'(i), 8'h00});
      @(posedge clk); #1;
      i_spi_rx_data = 8'h02;
      i_byte_valid  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("clear_taken", o_byte_taken, 1);
      nbusy = 0; bad_rx = 0; gaps = 0; tk_during = 0;
      fork
         begin
            for (int k = 0; k < 400 && o_busy; k++) begin
               nbusy++;
               if (o_rx_enable) bad_rx++;
               if (!o_img_wr_en) gaps++;
               if (o_byte_taken && k > 0) tk_during++;
               @(negedge clk);
            end
         end
         begin
            @(posedge clk); #1 i_byte_valid = 1'b0;
            @(posedge clk); #1 i_spi_rx_data = 8'h00; i_byte_valid = 1'b1;
         end
      join
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         if (o_byte_taken) got = 1;
         else @(negedge clk);
      end
      @(posedge clk); #1 i_byte_valid = 1'b0;
      chk("clear_cycles", nbusy, IMG_BYTES);
      chk("clear_rx_enable_low", bad_rx, 0);
      chk("clear_write_gaps", gaps, 0);
      chk("clear_held_byte_not_taken", tk_during, 0);
      chk("clear_held_byte_taken_after", got, 1);
      chk("clear_img_loaded", o_img_loaded, 0);
      chk("clear_writes_left", q_wr.size(), 0);

      // reset in the middle of a load
      send(8'h01, 0);
      for (int i = 0; i < 3; i++) begin
         q_wr.push_back({8'(i), 8'h30 + 8'(i)});
         send(8'h30 + 8'(i), 0);
      end
      @(negedge clk);
      chk("midload_busy", o_busy, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("midload_rst_outputs",
          {o_busy, o_rx_enable, o_img_loaded, o_cmd_error, o_img_wr_en, o_byte_taken, o_infer_start}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("after_rst_idle", {o_busy, o_rx_enable}, 2'b01);
      chk("final_queues_empty", q_wr.size() + q_inf.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
